kbd_scan_fifo: RTL
==================

KBD_SCAN_FIFO -- requirements
Module: kbd_scan_fifo

Interface
REQ-001 Parameter DATA_W, default 8, scan-code width in bits (4..16).
REQ-002 Parameter DEPTH, default 16, FIFO entries; power of two, 2..256.
REQ-003 Parameter PAR_ODD, default 1; 1 = odd parity expected, 0 = even.
REQ-004 pclk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 kbd_data  input  1  serial line, one bit per pclk, idle high.
REQ-007 ack  input  1  host acknowledge; its rising edge pops one entry.
REQ-008 clr_err  input  1  synchronous clear of the sticky error flags.
REQ-009 rd_data  output  DATA_W  head-of-FIFO scan code.
REQ-010 irq  output  1  high while the FIFO holds at least one entry.
REQ-011 count  output  $clog2(DEPTH)+1  number of entries held.
REQ-012 ovf  output  1  sticky overflow flag.
REQ-013 frame_err  output  1  sticky stop/parity error flag.

Function
REQ-014 Frame: start bit 0, DATA_W data bits LSB first, parity bit, stop bit 1; each bit occupies exactly one pclk cycle.
REQ-015 Receive FSM has states IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: sampled kbd_data=0 -> DATA, bit counter cleared; otherwise remain in IDLE.
REQ-017 DATA: shift in one bit per cycle; after DATA_W bits -> PARITY.
REQ-018 PARITY: capture the parity bit -> STOP.
REQ-019 STOP: kbd_data=1 and the frame is valid -> push the shift register into the FIFO; otherwise set frame_err and drop the frame; always -> IDLE.
REQ-020 A new start bit is recognised no earlier than the cycle after STOP; back-to-back frames need no idle gap.
REQ-021 irq and count are registered and update on the edge after the push/pop edge (one-cycle latency from the STOP cycle to irq).
REQ-022 rd_data shows the head entry whenever count>0, and all-zeros when empty.
REQ-023 Pop occurs when ack=1, the registered previous ack=0, and count>0; holding ack high pops only once.
REQ-024 Pop while empty is ignored, with no flag set.
REQ-025 Push while full without a simultaneous pop drops the new code, sets ovf, and leaves the FIFO contents unchanged.
REQ-026 Simultaneous push and pop: both succeed, count unchanged, including when full.
REQ-027 Read/write pointers wrap modulo DEPTH; count saturates at DEPTH, never above.
REQ-028 clr_err=1 clears ovf and frame_err on the next edge; a same-cycle error event wins and the flag stays set.

Reset
REQ-029 reset_n low immediately forces: FSM IDLE, pointers/count 0, rd_data 0, irq 0, ovf 0, frame_err 0, registered ack 0.
REQ-030 Reset asserted mid-frame discards the partial frame; after release, reception restarts only on a fresh start bit.

Configuration
REQ-031 Macro KBD_SCAN_PARITY_EN defined: a parity mismatch against PAR_ODD invalidates the frame (REQ-019).
REQ-032 Macro KBD_SCAN_PARITY_EN undefined: the parity bit is sampled and ignored; only the stop bit decides validity.

Verification
REQ-033 Reset, then frame 0xF4 with correct parity and stop -> irq=1, rd_data=0xF4, count=1; ack pulse -> irq=0, count=0, rd_data=0x00.
REQ-034 Sixteen frames 0x00..0x0F without ack, then frame 0xAA -> count=16, ovf=1; sixteen ack pulses read 0x00..0x0F in order.
REQ-035 Frame 0x1C with stop bit 0 -> no push, frame_err=1; clr_err pulse -> frame_err=0.
REQ-036 Frame 0x5A with wrong parity -> with KBD_SCAN_PARITY_EN: dropped, frame_err=1; without it: pushed, rd_data=0x5A.
REQ-037 FIFO full; ack rising edge on the same cycle as the STOP of frame 0x33 -> count stays 16, ovf=0, 0x33 at the tail.
REQ-038 reset_n pulsed low during data bit 4 of frame 0x77 -> count=0, irq=0; the following frame 0x12 is received correctly.

Source files
------------

// File: rtl/kbd_scan_fifo.sv
// kbd_scan_fifo: one-bit-per-clock keyboard frame receiver feeding a scan-code FIFO.
// Define KBD_SCAN_PARITY_EN to reject frames whose parity bit disagrees with PAR_ODD.
module kbd_scan_fifo #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int PAR_ODD = 1
) (
    input  logic                   pclk,
    input  logic                   reset_n,
    input  logic                   kbd_data,
    input  logic                   ack,
    input  logic                   clr_err,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   irq,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf,
    output logic                   frame_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(DATA_W);
    localparam logic PAR_SENSE = (PAR_ODD != 0);
`ifdef KBD_SCAN_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t            state;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_bit;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!kbd_data) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    // LSB arrives first, so shift in from the top
                    shreg   <= {kbd_data, shreg[DATA_W-1:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == BW'(DATA_W - 1)) state <= PARITY;
                end
                PARITY: begin
                    par_bit <= kbd_data;
                    state   <= STOP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic par_ok, frame_ok, push, bad_frame;

    assign par_ok    = ((^{shreg, par_bit}) == PAR_SENSE);
    assign frame_ok  = kbd_data && (!PAR_EN || par_ok);
    assign push      = (state == STOP) && frame_ok;
    assign bad_frame = (state == STOP) && !frame_ok;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              ack_q, pop, full, wr_en;
    logic [AW:0]       count_nxt;

    assign full  = (count == (AW+1)'(DEPTH));
    assign pop   = ack && !ack_q && (count != '0);
    // a pop on the same edge frees the slot, so a push into a full FIFO still lands
    assign wr_en = push && (!full || pop);

    always_comb begin
        count_nxt = count;
        if (wr_en && !pop)      count_nxt = count + 1'b1;
        else if (!wr_en && pop) count_nxt = count - 1'b1;
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            irq       <= 1'b0;
            ack_q     <= 1'b0;
            ovf       <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            ack_q <= ack;
            count <= count_nxt;
            irq   <= (count_nxt != '0);
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (push && !wr_en) ovf <= 1'b1;
            else if (clr_err)   ovf <= 1'b0;
            if (bad_frame)    frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
        end
    end

    always_ff @(posedge pclk) begin
        if (wr_en) mem[wr_ptr] <= shreg;
    end

    assign rd_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule
